// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, WIDTH iterations.
// Level-held start / done_flag handshake shared with the shift-add multiplier.
module seq_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done_flag,
   output logic             div_by_zero
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StCalc    = 2'b01,
      StFinish  = 2'b10,
      StIllegal = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] q_sh_q, q_sh_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic [WIDTH:0]   acc_step;
   logic [WIDTH-1:0] q_step;

   // The partial remainder is always below the divisor, so its top bit stays zero.
   logic unused_acc_msb;
   assign unused_acc_msb = acc_q[WIDTH];

   // Full WIDTH+1-bit compare: the shifted-in bit can push trial past WIDTH bits.
   assign trial    = {acc_q[WIDTH-1:0], q_sh_q[WIDTH-1]};
   assign fits     = trial >= {1'b0, dvs_q};
   assign diff     = trial - {1'b0, dvs_q};
   assign acc_step = fits ? diff : trial;
   assign q_step   = {q_sh_q[WIDTH-2:0], fits};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         acc_q   <= '0;
         q_sh_q  <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         q_sh_q  <= q_sh_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      q_sh_d  = q_sh_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               if (divisor != '0) begin
                  q_sh_d  = dividend;
                  dvs_d   = divisor;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = StCalc;
               end else begin
                  quot_d  = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = StFinish;
               end
            end
         end
         StCalc: begin
            // Abort wins even on the final step, so results are left untouched.
            if (!start) begin
               state_d = StIdle;
            end else begin
               acc_d  = acc_step;
               q_sh_d = q_step;
               cnt_d  = cnt_q + CntW'(1);
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  quot_d  = q_step;
                  rem_d   = acc_step[WIDTH-1:0];
                  dbz_d   = 1'b0;
                  state_d = StFinish;
               end
            end
         end
         StFinish: begin
            if (!start) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy        = (state_q == StCalc);
   assign done_flag   = (state_q == StFinish);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative unsigned restoring divider. It is the inverse companion to the team's shift-add multiplier control path, and uses the same level-held `start` / `done_flag` handshake. It produces one quotient bit per clock and delivers `WIDTH`-bit quotient and remainder after `WIDTH` iteration cycles. It sits beside the multiplier under the arithmetic unit's top-level sequencer, which drives `start` and waits on `done_flag`.

## Interface
- `WIDTH`, default 8: operand/result width; legal range 2..16.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level request; must stay high for the whole operation.
- `dividend`  in  WIDTH  numerator; sampled only on the IDLE->CALC edge.
- `divisor`  in  WIDTH  denominator; sampled only on the IDLE->CALC edge.
- `quotient`  out  WIDTH  registered result.
- `remainder`  out  WIDTH  registered result.
- `busy`  out  1  high in CALC.
- `done_flag`  out  1  high in FINISH.
- `div_by_zero`  out  1  registered; set with results when the sampled divisor == 0.

## Operation
- States: IDLE (2'b00), CALC (2'b01), FINISH (2'b10). The encoding 2'b11 is illegal and goes to IDLE next cycle.
- Internal registers:
  - `acc`: WIDTH+1 bits, partial remainder.
  - `q_sh`: WIDTH bits, dividend shifting out / quotient shifting in.
  - `dvs`: WIDTH bits, latched divisor.
  - `cnt`: clog2(WIDTH+1) bits.
- IDLE:
  - `start`=1 and `divisor`!=0: `q_sh`<=`dividend`, `dvs`<=`divisor`, `acc`<=0, `cnt`<=0, go to CALC.
  - `start`=1 and `divisor`==0: go straight to FINISH. Set `quotient`<=all ones, `remainder`<=`dividend`, `div_by_zero`<=1.
  - `start`=0: stay in IDLE.
- CALC, one step per cycle:
  - t = {`acc`[WIDTH-1:0], `q_sh`[WIDTH-1]}.
  - If t >= {1'b0,`dvs`}: `acc`<=t-`dvs`, `q_sh`<={`q_sh`[WIDTH-2:0],1}.
  - Otherwise: `acc`<=t, `q_sh`<={`q_sh`[WIDTH-2:0],0}.
  - `cnt`<=`cnt`+1.
  - The compare is WIDTH+1 bits wide and never truncates.
- CALC exit:
  - On the step where `cnt`==WIDTH-1, go to FINISH. Load `quotient`<=final `q_sh`, `remainder`<=final `acc`[WIDTH-1:0], `div_by_zero`<=0.
  - `start`=0 in any CALC cycle aborts to IDLE. `quotient`, `remainder` and `div_by_zero` keep their previous values.
- FINISH:
  - Hold while `start`=1.
  - `start`=0 returns to IDLE. Results remain held after `done_flag` drops.
- `busy` and `done_flag` are decoded from the state register only (Moore outputs), never from `start`.
- Operand changes after the IDLE->CALC edge have no effect.
- A new operation requires `start` to drop for at least one cycle so the FSM passes through IDLE.

## Timing
- Reset values: state=IDLE, `quotient`=0, `remainder`=0, `busy`=0, `done_flag`=0, `div_by_zero`=0. All internal registers are 0.
- Reset is asynchronous. Asserting `rst` mid-CALC or in FINISH clears everything immediately; there is no partial result.
- Normal latency:
  - Edge 0 samples `start`=1 in IDLE; `busy`=1 after edge 0.
  - Edges 1..WIDTH run the iterations; FINISH is entered at edge WIDTH.
  - `done_flag`=1 from after edge WIDTH. For WIDTH=8 that is 8 cycles after the first sampled edge, with `busy` high for exactly WIDTH cycles.
- Divide-by-zero latency: `done_flag`=1 after edge 0 (one cycle); `busy` never asserts.
- `quotient`/`remainder` change only on the FINISH-entry edge. They are stable whenever `done_flag`=1.
- Simultaneous events:
  - `start` falling on the final CALC edge counts as an abort; results are not updated.
  - `start` falling in FINISH: IDLE on the next edge, `done_flag`=0.

## Test plan
- WIDTH=8, `dividend`=100, `divisor`=7, `start` held → `done_flag` rises 8 cycles after first sample with `quotient`=14, `remainder`=2, `div_by_zero`=0; `busy` high exactly 8 cycles.
- Boundaries:
  - 255/1 → `quotient`=255, `remainder`=0.
  - 5/9 → `quotient`=0, `remainder`=5.
  - 255/255 → `quotient`=1, `remainder`=0.
  - 128/3 → `quotient`=42, `remainder`=2.
- `divisor`=0, `dividend`=77 → after 1 cycle `done_flag`=1, `div_by_zero`=1, `quotient`=255, `remainder`=77, `busy` never high.
- Abort: complete 100/7, drop `start`, run 200/9 and drop `start` after 4 CALC cycles → IDLE next edge; `quotient`/`remainder` still 14/2; `done_flag` never rises.
- Reset mid-CALC: assert `rst` asynchronously between edges → all outputs 0 immediately. Release, then 60/4 → 15/0 after full latency.
- Back-to-back: hold `start` 3 extra cycles in FINISH (`done_flag` stays 1, results stable, operand changes ignored), drop one cycle, then 200/13 → `quotient`=15, `remainder`=5.
